// File: rtl/lsu_pkg.sv
// Shared types and helpers for the RV32I load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} lsu_state_e;

  // Legal funct3 for the access kind, plus natural alignment of halfwords and words.
  function automatic logic is_legal(input logic is_store, input logic [2:0] funct3,
                                    input logic [1:0] offset);
    logic ok;
    if (is_store) ok = funct3 inside {F3_B, F3_H, F3_W};
    else          ok = funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    if (funct3[1:0] == 2'b01 && offset[0]) ok = 1'b0;
    if (funct3 == F3_W && offset != 2'b00) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane merge for stores and extract/extend for loads.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  output logic [31:0] merged_o,
  output logic [31:0] load_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word_i[{offset_i, 3'b000} +: 8];
  assign half_sel = word_i[{offset_i[1], 4'b0000} +: 16];

  always_comb begin
    merged_o = word_i;
    case (funct3_i[1:0])
      2'b00:   merged_o[{offset_i, 3'b000} +: 8] = wdata_i[7:0];
      2'b01:   merged_o[{offset_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      2'b10:   merged_o = wdata_i;
      default: merged_o = word_i;
    endcase
  end

  always_comb begin
    load_data_o = '0;
    case (funct3_i)
      F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
      F3_W:    load_data_o = word_i;
      F3_BU:   load_data_o = {24'h0, byte_sel};
      F3_HU:   load_data_o = {16'h0, half_sel};
      default: load_data_o = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I data-memory initiator: aligned word reads, read-modify-write for sub-word stores.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_is_store,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic            resp_err,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] mem_address,
  output logic [XLEN-1:0] mem_write_data,
  output logic            mem_write_enable,
  input  logic [XLEN-1:0] mem_read_data
);

  lsu_state_e      state_q, state_d;
  logic            is_store_q, err_q;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] addr_q, wdata_q, rdata_q;
  logic [XLEN-1:0] merged, extracted;

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      is_store_q <= 1'b0;
      err_q      <= 1'b0;
      funct3_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      if (state_q == StIdle && req_valid) begin
        is_store_q <= req_is_store;
        funct3_q   <= req_funct3;
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
        err_q      <= !is_legal(req_is_store, req_funct3, req_addr[1:0]);
      end
      if (state_q == StRead) rdata_q <= mem_read_data;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d = is_legal(req_is_store, req_funct3, req_addr[1:0]) ? StRead : StResp;
        end
      end
      StRead:  state_d = is_store_q ? StWrite : StResp;
      StWrite: state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  lsu_align u_align (
    .word_i      (rdata_q),
    .wdata_i     (wdata_q),
    .funct3_i    (funct3_q),
    .offset_i    (addr_q[1:0]),
    .merged_o    (merged),
    .load_data_o (extracted)
  );

  always_comb begin
    req_ready        = (state_q == StIdle);
    resp_valid       = (state_q == StResp);
    resp_err         = (state_q == StResp) && err_q;
    load_data        = (state_q == StResp && !is_store_q && !err_q) ? extracted : '0;
    // Gate with rst so a reset landing on the WRITE cycle never commits the word.
    mem_write_enable = (state_q == StWrite) && !rst;
    mem_write_data   = merged;
    mem_address      = {addr_q[XLEN-1:2], 2'b00};
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench: byte-level reference memory model against the load/store unit.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] load_data, mem_address, mem_write_data, mem_read_data;
  logic        mem_write_enable;

  logic [31:0] mem [0:255];
  logic [7:0]  ref_b [0:1023];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_address[9:2]];

  load_store_unit #(.XLEN(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_is_store     (req_is_store),
    .req_funct3       (req_funct3),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_err         (resp_err),
    .load_data        (load_data),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable),
    .mem_read_data    (mem_read_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_word(input int a, input logic [31:0] v);
    int base;
    base = a & ~3;
    mem[base >> 2] = v;
    for (int i = 0; i < 4; i++) ref_b[base + i] = v[8*i +: 8];
  endtask

  // Present a request and wait (bounded) until it is accepted; returns #1 after the accept edge.
  task automatic send(input logic st, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd);
    int n;
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("accept_timeout", {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1;
  endtask

  // Follow one accepted request through to its response, checking against the byte model.
  task automatic check_txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd);
    logic [7:0]  b [4];
    logic        err;
    logic [31:0] exp_ld, exp_wr;
    int base, off, lat, wr_cnt;
    base = int'(a) & ~3;
    off  = int'(a[1:0]);
    for (int i = 0; i < 4; i++) b[i] = ref_b[base + i];
    if (st) err = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    else    err = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if ((f3 == 3'd1 || f3 == 3'd5) && off % 2 != 0) err = 1'b1;
    if (f3 == 3'd2 && off != 0) err = 1'b1;
    exp_ld = 32'h0;
    if (!st && !err) begin
      case (f3)
        3'd0: exp_ld = {{24{b[off][7]}}, b[off]};
        3'd1: exp_ld = {{16{b[off+1][7]}}, b[off+1], b[off]};
        3'd2: exp_ld = {b[3], b[2], b[1], b[0]};
        3'd4: exp_ld = {24'h0, b[off]};
        default: exp_ld = {16'h0, b[off+1], b[off]};
      endcase
    end
    if (st && !err) begin
      if (f3 == 3'd0) b[off] = wd[7:0];
      else if (f3 == 3'd1) begin b[off] = wd[7:0]; b[off+1] = wd[15:8]; end
      else begin b[0] = wd[7:0]; b[1] = wd[15:8]; b[2] = wd[23:16]; b[3] = wd[31:24]; end
    end
    exp_wr = {b[3], b[2], b[1], b[0]};
    lat = err ? 1 : (st ? 3 : 2);
    wr_cnt = 0;
    for (int k = 1; k <= lat; k++) begin
      chk("busy_ready", {31'h0, req_ready}, 32'h0);
      chk("resp_cycle", {31'h0, resp_valid}, (k == lat) ? 32'h1 : 32'h0);
      if (mem_write_enable) begin
        wr_cnt++;
        chk("wr_cycle", k, 32'd2);
        chk("wr_addr", mem_address, a & ~32'h3);
        chk("wr_data", mem_write_data, exp_wr);
        mem[mem_address[9:2]] = mem_write_data;
      end
      if (k == lat) begin
        chk("resp_err", {31'h0, resp_err}, {31'h0, err});
        chk("load_data", load_data, exp_ld);
      end else begin
        @(posedge clk); #1;
      end
    end
    chk("wr_count", wr_cnt, (st && !err) ? 32'd1 : 32'd0);
    if (st && !err) for (int i = 0; i < 4; i++) ref_b[base + i] = b[i];
    @(posedge clk); #1;
    chk("resp_single", {31'h0, resp_valid}, 32'h0);
    chk("idle_ready", {31'h0, req_ready}, 32'h1);
  endtask

  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd);
    send(st, f3, a, wd);
    req_valid = 1'b0;
    check_txn(st, f3, a, wd);
  endtask

  initial begin
    logic        r_st;
    logic [2:0]  r_f3;
    logic [31:0] r_a, r_wd;
    for (int i = 0; i < 256; i++) set_word(4 * i, $urandom);
    rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0;
    req_funct3 = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wen", {31'h0, mem_write_enable}, 32'h0);
    rst = 1'b0;
    chk("rst_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_resp", {31'h0, resp_valid}, 32'h0);
    chk("rst_err", {31'h0, resp_err}, 32'h0);
    chk("rst_ld", load_data, 32'h0);
    chk("rst_wen2", {31'h0, mem_write_enable}, 32'h0);

    // Directed loads from a known word
    set_word(32'h40, 32'h8899AABB);
    do_req(1'b0, 3'd0, 32'h41, 32'h0);
    chk("lb_41", load_data, 32'h0);
    do_req(1'b0, 3'd4, 32'h41, 32'h0);
    do_req(1'b0, 3'd1, 32'h42, 32'h0);
    do_req(1'b0, 3'd5, 32'h42, 32'h0);
    do_req(1'b0, 3'd2, 32'h40, 32'h0);

    // Directed stores
    do_req(1'b1, 3'd0, 32'h43, 32'h12345677);
    chk("sb_mem", mem[32'h40 >> 2], 32'h7799AABB);
    set_word(32'h40, 32'h8899AABB);
    do_req(1'b1, 3'd1, 32'h40, 32'hDEADBEEF);
    chk("sh_mem", mem[32'h40 >> 2], 32'h8899BEEF);
    do_req(1'b1, 3'd2, 32'h44, 32'hCAFEF00D);
    chk("sw_mem", mem[32'h44 >> 2], 32'hCAFEF00D);

    // Error cases
    do_req(1'b0, 3'd2, 32'h42, 32'h0);
    do_req(1'b1, 3'd1, 32'h41, 32'h0);
    do_req(1'b0, 3'd3, 32'h40, 32'h0);
    do_req(1'b1, 3'd4, 32'h40, 32'h0);

    // Reset landing on the WRITE cycle of an SB
    set_word(32'h40, 32'h8899AABB);
    send(1'b1, 3'd0, 32'h43, 32'h12345677);
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_wen", {31'h0, mem_write_enable}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_ready", {31'h0, req_ready}, 32'h1);
    chk("abort_resp", {31'h0, resp_valid}, 32'h0);
    @(posedge clk); #1;
    chk("abort_resp2", {31'h0, resp_valid}, 32'h0);
    do_req(1'b0, 3'd2, 32'h40, 32'h0);

    // Second request held while busy: must wait for the first to finish
    send(1'b0, 3'd2, 32'h40, 32'h0);
    req_is_store = 1'b1; req_funct3 = 3'd2; req_addr = 32'h48; req_wdata = 32'h0BADF00D;
    check_txn(1'b0, 3'd2, 32'h40, 32'h0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_txn(1'b1, 3'd2, 32'h48, 32'h0BADF00D);
    do_req(1'b0, 3'd2, 32'h48, 32'h0);

    // Random traffic
    for (int n = 0; n < 80; n++) begin
      r_st = 1'($urandom_range(0, 1));
      r_f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) r_f3 = r_st ? 3'($urandom_range(0, 2))
                                                 : 3'($urandom_range(0, 5));
      r_a  = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) begin
        if (r_f3[1:0] == 2'b01) r_a[0] = 1'b0;
        if (r_f3 == 3'd2) r_a[1:0] = 2'b00;
      end
      r_wd = $urandom;
      do_req(r_st, r_f3, r_a, r_wd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
